multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle main-control state machine for the RISC-V core. It takes the opcode from the instruction register and sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and write-back over several clock cycles. It replaces the purely combinational opcode decoder once the core moves from single-cycle to multicycle. It also handles memory wait states through a ready handshake, traps illegal opcodes, and counts retired instructions.

## Interface
- CNT_WIDTH, 32, width of the retired-instruction counter
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- OP_i  input  7  opcode field of the instruction register (IR[6:0]), valid from DECODE onward
- Mem_Ready_i  input  1  memory completes the current read/write this cycle
- PC_Write_o  output  1  unconditional PC load
- PC_Write_Cond_o  output  1  PC load if ALU zero flag set (beq)
- PC_Src_o  output  1  0 = ALU result, 1 = ALUOut register
- IorD_o  output  1  memory address: 0 = PC, 1 = ALUOut
- Mem_Read_o  output  1  memory read strobe
- Mem_Write_o  output  1  memory write strobe
- IR_Write_o  output  1  load instruction register (also latches OldPC)
- Mem_to_Reg_o  output  1  write-back source: 0 = ALUOut, 1 = MDR
- Reg_Write_o  output  1  register-file write enable
- ALU_Src_A_o  output  2  00 PC, 01 OldPC, 10 register A, 11 zero
- ALU_Src_B_o  output  2  00 register B, 01 constant 4, 10 immediate
- ALU_Op_o  output  3  000 R-type, 001 I-logic, 010 U-type, 011 add, 100 branch compare
- Illegal_o  output  1  sticky trap flag
- Retired_Count_o  output  CNT_WIDTH  instructions completed since reset
- State_o  output  4  current state encoding (debug)

## Operation
- Opcodes: R 0110011, I-logic 0010011, LUI 0110111, load 0000011, store 0100011, beq 1100011. Anything else is illegal.
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, EXEC_U 4, ALU_WB 5, MEM_ADDR 6, MEM_READ 7, MEM_WB 8, MEM_WRITE 9, BRANCH 10, TRAP 15.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: IorD=0, Mem_Read=1, A=00, B=01, ALU_Op=011, PC_Src=0.
  - IR_Write and PC_Write equal Mem_Ready_i (Mealy outputs).
  - Stays in FETCH until Mem_Ready_i, then goes to DECODE.
- DECODE: A=01, B=10, ALU_Op=011 (ALUOut receives the branch target). Next state by OP_i: EXEC_R, EXEC_I, EXEC_U, MEM_ADDR (load/store), BRANCH, or TRAP.
- EXEC_R: A=10, B=00, Op=000, then ALU_WB.
- EXEC_I: A=10, B=10, Op=001, then ALU_WB.
- EXEC_U: A=11, B=10, Op=010, then ALU_WB.
- ALU_WB: Reg_Write=1, Mem_to_Reg=0, then FETCH.
- MEM_ADDR: A=10, B=10, Op=011. Goes to MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: IorD=1, Mem_Read=1. Holds until Mem_Ready_i, then MEM_WB.
- MEM_WB: Reg_Write=1, Mem_to_Reg=1, then FETCH.
- MEM_WRITE: IorD=1, Mem_Write=1. Holds until Mem_Ready_i, then FETCH.
- BRANCH: A=10, B=00, Op=100, PC_Write_Cond=1, PC_Src=1, then FETCH.
- TRAP: absorbing state; only reset exits. Illegal_o=1, all strobes 0.
- Retired_Count_o increments by 1 on each transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE or BRANCH. It wraps modulo 2^CNT_WIDTH and never increments on the TRAP path.

## Timing
- Reset (async, any state, including mid-wait):
  - State goes to FETCH, Retired_Count_o=0, Illegal_o=0.
  - While reset is high, all strobes (PC_Write, PC_Write_Cond, IR_Write, Mem_Read, Mem_Write, Reg_Write) are forced to 0. Mux selects are don't-care.
  - The first fetch read issues in the first cycle after reset deasserts.
- Latency with Mem_Ready_i held high:
  - Branch: 3 cycles.
  - R, I, LUI and store: 4 cycles.
  - Load: 5 cycles.
- Each cycle Mem_Ready_i is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. The strobes stay asserted and the address select stays stable during the wait.
- Mem_Ready_i is ignored in all other states.
- OP_i is sampled only in DECODE and MEM_ADDR. The datapath holds the IR stable until the next FETCH completes.
- Counter increment and the state update happen on the same edge. Retired_Count_o is registered.

## Test plan
- Reset, Mem_Ready_i=1, OP_i=0110011 -> State_o sequence 0,1,2,5,0. Reg_Write_o=1 only in state 5. Retired_Count_o=1 after 4 cycles.
- Load 0000011 with Mem_Ready_i low for 2 cycles in MEM_READ -> sequence 0,1,6,7,7,7,8,0. Mem_Read_o=1 and IorD_o=1 for all three MEM_READ cycles. Mem_to_Reg_o=1 in state 8.
- Store 0100011, Mem_Ready_i=1 -> sequence 0,1,6,9,0. Mem_Write_o=1 for exactly 1 cycle. Reg_Write_o never asserted.
- beq 1100011 -> sequence 0,1,10,0. PC_Write_Cond_o=1 and PC_Src_o=1 in state 10. In FETCH: PC_Write_o=1, ALU_Src_B_o=01.
- Opcode 1111111 -> State_o=15 from the 3rd cycle on, Illegal_o=1 held for 20+ cycles, counter unchanged. Reset then clears Illegal_o to 0 and State_o to 0.
- CNT_WIDTH=4, 17 R-type instructions -> Retired_Count_o wraps to 1. Async reset asserted mid-MEM_WRITE -> strobes drop immediately, counter 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main-control FSM and the datapath.
// The controller is the master: it reads the opcode and memory ready, drives everything else.
interface multicycle_control_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           op;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 pc_src;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [2:0]           alu_op;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired_count;
  logic [3:0]           state;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal,
           retired_count, state
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal,
           retired_count, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main control: sequences fetch/decode/execute/memory/write-back,
// stalls on memory ready, traps illegal opcodes and counts retired instructions.
module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    EXEC_U    = 4'd4,
    ALU_WB    = 4'd5,
    MEM_ADDR  = 4'd6,
    MEM_READ  = 4'd7,
    MEM_WB    = 4'd8,
    MEM_WRITE = 4'd9,
    BRANCH    = 4'd10,
    TRAP      = 4'd15
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 retire;

  logic       pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b;
  logic [2:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    unique case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b011;
        // IR and PC load in the same cycle the memory delivers the word
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
        case (bus.op)
          OP_R:                state_d = EXEC_R;
          OP_I:                state_d = EXEC_I;
          OP_LUI:              state_d = EXEC_U;
          OP_LOAD, OP_STORE:   state_d = MEM_ADDR;
          OP_BEQ:              state_d = BRANCH;
          default:             state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        state_d   = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 3'b001;
        state_d   = ALU_WB;
      end
      EXEC_U: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        state_d   = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
        if (bus.op == OP_LOAD)       state_d = MEM_READ;
        else if (bus.op == OP_STORE) state_d = MEM_WRITE;
        else                         state_d = TRAP;
      end
      MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 2'b10;
        alu_op        = 3'b100;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
        state_d       = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // state is already FETCH during reset; keep its read strobe off until release
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign retire = (state_d == FETCH) &&
                  ((state_q == ALU_WB) || (state_q == MEM_WB) ||
                   (state_q == MEM_WRITE) || (state_q == BRANCH));

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.pc_src        = pc_src;
  assign bus.iord          = iord;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.illegal       = illegal;
  assign bus.retired_count = count_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (32-bit and 4-bit counters) share stimulus
// and are checked cycle by cycle against an instruction-level sequence model.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_cnt = '0;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } step_t;
  step_t plan[$];

  multicycle_control_if #(.CNT_WIDTH(32)) bus32 ();
  multicycle_control_if #(.CNT_WIDTH(4))  bus4 ();

  assign bus32.op = op;
  assign bus32.mem_ready = mem_ready;
  assign bus4.op = op;
  assign bus4.mem_ready = mem_ready;

  multicycle_control #(.CNT_WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  multicycle_control #(.CNT_WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  // {state, pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal}
  logic [20:0] act32, act4;
  assign act32 = {bus32.state, bus32.pc_write, bus32.pc_write_cond, bus32.pc_src, bus32.iord,
                  bus32.mem_read, bus32.mem_write, bus32.ir_write, bus32.mem_to_reg,
                  bus32.reg_write, bus32.alu_src_a, bus32.alu_src_b, bus32.alu_op, bus32.illegal};
  assign act4  = {bus4.state, bus4.pc_write, bus4.pc_write_cond, bus4.pc_src, bus4.iord,
                  bus4.mem_read, bus4.mem_write, bus4.ir_write, bus4.mem_to_reg,
                  bus4.reg_write, bus4.alu_src_a, bus4.alu_src_b, bus4.alu_op, bus4.illegal};

  // state, strobes and illegal flag; mux selects are free while reset is high
  localparam logic [20:0] RESET_MASK = 21'h1F9D01;

  localparam logic [6:0] LEGAL_OPS [6] = '{7'b0110011, 7'b0010011, 7'b0110111,
                                           7'b0000011, 7'b0100011, 7'b1100011};

  function automatic logic [20:0] exp_vec(logic [3:0] st, logic r);
    logic pw = 0, pwc = 0, ps = 0, io = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rw = 0, il = 0;
    logic [1:0] a = 2'b00, b = 2'b00;
    logic [2:0] aop = 3'b000;
    case (st)
      4'd0:  begin mr = 1; b = 2'b01; aop = 3'b011; pw = r; irw = r; end
      4'd1:  begin a = 2'b01; b = 2'b10; aop = 3'b011; end
      4'd2:  begin a = 2'b10; b = 2'b00; aop = 3'b000; end
      4'd3:  begin a = 2'b10; b = 2'b10; aop = 3'b001; end
      4'd4:  begin a = 2'b11; b = 2'b10; aop = 3'b010; end
      4'd5:  begin rw = 1; end
      4'd6:  begin a = 2'b10; b = 2'b10; aop = 3'b011; end
      4'd7:  begin io = 1; mr = 1; end
      4'd8:  begin rw = 1; m2r = 1; end
      4'd9:  begin io = 1; mw = 1; end
      4'd10: begin a = 2'b10; aop = 3'b100; pwc = 1; ps = 1; end
      4'd15: begin il = 1; end
      default: ;
    endcase
    return {st, pw, pwc, ps, io, mr, mw, irw, m2r, rw, a, b, aop, il};
  endfunction

  task automatic add(input int st, input logic r);
    step_t s;
    s.st  = st[3:0];
    s.rdy = r;
    plan.push_back(s);
  endtask

  // Expected state walk of one instruction: fw fetch stalls, mw memory stalls.
  task automatic build_instr(input logic [6:0] opc, input int fw, input int mw);
    plan.delete();
    repeat (fw) add(0, 1'b0);
    add(0, 1'b1);
    add(1, 1'($urandom_range(0, 1)));
    case (opc)
      7'b0110011: begin add(2, 1'($urandom_range(0, 1))); add(5, 1'($urandom_range(0, 1))); end
      7'b0010011: begin add(3, 1'($urandom_range(0, 1))); add(5, 1'($urandom_range(0, 1))); end
      7'b0110111: begin add(4, 1'($urandom_range(0, 1))); add(5, 1'($urandom_range(0, 1))); end
      7'b0000011: begin
        add(6, 1'($urandom_range(0, 1)));
        repeat (mw) add(7, 1'b0);
        add(7, 1'b1);
        add(8, 1'($urandom_range(0, 1)));
      end
      7'b0100011: begin
        add(6, 1'($urandom_range(0, 1)));
        repeat (mw) add(9, 1'b0);
        add(9, 1'b1);
      end
      7'b1100011: add(10, 1'($urandom_range(0, 1)));
      default: repeat (22) add(15, 1'($urandom_range(0, 1)));
    endcase
  endtask

  // Called at a negedge; returns at a later negedge.
  task automatic run_plan(input string name, input logic [6:0] opc, input logic retires);
    logic [20:0] e;
    for (int i = 0; i < plan.size(); i++) begin
      op = opc;
      mem_ready = plan[i].rdy;
      #1;
      e = exp_vec(plan[i].st, plan[i].rdy);
      checks++;
      if (act32 !== e) begin
        errors++;
        $display("FAIL %s step %0d dut32 outputs got %h want %h", name, i, act32, e);
      end
      checks++;
      if (act4 !== e) begin
        errors++;
        $display("FAIL %s step %0d dut4 outputs got %h want %h", name, i, act4, e);
      end
      checks++;
      if (bus32.retired_count !== model_cnt) begin
        errors++;
        $display("FAIL %s step %0d count32 got %0d want %0d", name, i, bus32.retired_count, model_cnt);
      end
      checks++;
      if (bus4.retired_count !== model_cnt[3:0]) begin
        errors++;
        $display("FAIL %s step %0d count4 got %0d want %0d", name, i, bus4.retired_count, model_cnt[3:0]);
      end
      @(negedge clk);
    end
    if (retires) model_cnt = model_cnt + 1;
  endtask

  // Asserts reset off-edge, checks its immediate effect, releases at the next negedge.
  task automatic apply_reset(input string name);
    reset = 1'b1;
    #1;
    checks++;
    if ((act32 & RESET_MASK) !== 21'h0 || bus32.retired_count !== 32'd0) begin
      errors++;
      $display("FAIL %s dut32 got %h cnt %0d want strobes/state 0 cnt 0", name, act32 & RESET_MASK, bus32.retired_count);
    end
    checks++;
    if ((act4 & RESET_MASK) !== 21'h0 || bus4.retired_count !== 4'd0) begin
      errors++;
      $display("FAIL %s dut4 got %h cnt %0d want strobes/state 0 cnt 0", name, act4 & RESET_MASK, bus4.retired_count);
    end
    model_cnt = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op = 7'd0;
    mem_ready = 1'b0;
    #3;
    checks++;
    if ((act32 & RESET_MASK) !== 21'h0 || bus32.retired_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle got %h cnt %0d want 0", act32 & RESET_MASK, bus32.retired_count);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if ((act4 & RESET_MASK) !== 21'h0 || (act32 & RESET_MASK) !== 21'h0) begin
      errors++;
      $display("FAIL reset_ready got %h/%h want 0", act32 & RESET_MASK, act4 & RESET_MASK);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    build_instr(7'b0110011, 0, 0);
    run_plan("r_type", 7'b0110011, 1'b1);
    checks++;
    if (bus32.retired_count !== 32'd1) begin
      errors++;
      $display("FAIL r_type_retired got %0d want 1", bus32.retired_count);
    end
    build_instr(7'b0000011, 0, 2);
    run_plan("load_wait2", 7'b0000011, 1'b1);
    build_instr(7'b0100011, 0, 0);
    run_plan("store", 7'b0100011, 1'b1);
    build_instr(7'b1100011, 0, 0);
    run_plan("beq", 7'b1100011, 1'b1);
    build_instr(7'b0010011, 2, 0);
    run_plan("i_fetch_wait", 7'b0010011, 1'b1);
    build_instr(7'b0110111, 0, 0);
    run_plan("lui", 7'b0110111, 1'b1);
  endtask

  task automatic test_random_mix();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] o;
      o = LEGAL_OPS[$urandom_range(0, 5)];
      build_instr(o, $urandom_range(0, 2), $urandom_range(0, 2));
      run_plan("random_mix", o, 1'b1);
    end
  endtask

  task automatic test_trap();
    logic [6:0] bad;
    build_instr(7'b1111111, 0, 0);
    run_plan("trap_7f", 7'b1111111, 1'b0);
    apply_reset("trap_7f_reset");
    do bad = 7'($urandom);
    while (bad inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011, 7'b0100011, 7'b1100011});
    build_instr(bad, 1, 0);
    run_plan("trap_rand", bad, 1'b0);
    apply_reset("trap_rand_reset");
  endtask

  task automatic test_wrap();
    apply_reset("wrap_reset");
    for (int n = 0; n < 17; n++) begin
      build_instr(7'b0110011, 0, 0);
      run_plan("wrap", 7'b0110011, 1'b1);
    end
    checks++;
    if (bus4.retired_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_count4 got %0d want 1", bus4.retired_count);
    end
  endtask

  task automatic test_reset_mid_store();
    build_instr(7'b0100011, 0, 3);
    void'(plan.pop_back());
    void'(plan.pop_back());
    run_plan("store_stall", 7'b0100011, 1'b0);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (bus32.mem_write !== 1'b1 || bus32.state !== 4'd9) begin
      errors++;
      $display("FAIL store_hold got mem_write %b state %0d want 1 9", bus32.mem_write, bus32.state);
    end
    apply_reset("reset_mid_store");
    build_instr(7'b1100011, 0, 0);
    run_plan("after_reset_beq", 7'b1100011, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_mix();
    test_trap();
    test_wrap();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
